// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU Valid/RW/Ready handshake: captures one request,
// inserts WAIT_CYCLES wait states, then writes or reads an internal word array.
module mem_bus_responder #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              rw,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy,
    output logic              overrun
);

    localparam int              IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH:0] LP_DEPTH = (AWIDTH+1)'(DEPTH);
    localparam logic [3:0]      LP_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_rdata;
    logic              r_ready;
    logic              r_err;
    logic              r_busy;
    logic              r_overrun;
    logic [DWIDTH-1:0] r_mem [DEPTH];

    logic              w_in_range;
    logic [IDXW-1:0]   w_idx;

    assign w_in_range = ({1'b0, r_addr} < LP_DEPTH);
    assign w_idx      = r_addr[IDXW-1:0];

    // Array has no reset; the write is gated by ACCESS, which reset forces away from.
    always_ff @(posedge clk) begin
        if (r_state == ST_ACCESS && !r_rw && w_in_range)
            r_mem[w_idx] <= r_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        r_rw    <= rw;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_busy  <= 1'b1;
                        if (LP_WAIT == 4'd0) begin
                            r_state <= ST_ACCESS;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LP_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (valid)
                        r_overrun <= 1'b1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (valid)
                        r_overrun <= 1'b1;
                    if (r_rw)
                        r_rdata <= w_in_range ? r_mem[w_idx] : '0;
                    r_err   <= !w_in_range;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata   = r_rdata;
    assign ready   = r_ready;
    assign err     = r_err;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule
